cache_control: RTL and testbench

Control FSM for the 2-way set-associative L1 cache, sitting between the CPU memory port and physical memory and driving the cache datapath's write strobes and mux selects. Per request it decides hit/miss from the datapath's tag-check results, updates LRU and dirty state on hits, writes back a dirty victim line, then allocates the missed line from physical memory. The block owns every handshake with the CPU and physical memory.

---
 rtl/lc3b_types.sv | 25 ++
 rtl/cache_control.sv | 166 ++++++++++++++++
 tb/tb_cache_control.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types and widths for the L1 cache control slice.
//   line_t   : one 128-bit cache line
//   tag_t    : 9-bit stored tag
//   index_t  : 3-bit set index
//   cache_state_t : control FSM states (IDLE, WRITEBACK, ALLOCATE)
package lc3b_types;

  localparam int LINE_W   = 128;
  localparam int TAG_W    = 9;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 4;
  localparam int ADDR_W   = 16;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

endpackage

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache.
// Decides hit/miss from the datapath tag checks, updates LRU/dirty state on
// hits, writes back a dirty victim, then fills the missed line from pmem.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   mem_read/mem_write/mem_address  CPU request (held until mem_resp)
//   mem_resp                     one-cycle request-complete pulse
//   hit, tag1_hit, tag2_hit      datapath tag-check results
//   lru_out, dirty_1, dirty_2    LRU way / dirty bits of the current set
//   tag_1, tag_2, index          stored tags and current set index
//   data_1, data_2               stored lines of both ways
//   write_set1/2, write_lru      datapath array write enables
//   lru_val, dirty_in            data for the LRU / dirty arrays
//   memcachedatamux_sel          0 = cache line, 1 = pmem_rdata
//   datamux_1_sel/datamux_2_sel  0 = line, 1 = line merged with mem_wdata
//   pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_resp  physical memory
//   o_dbg_state                  current FSM state, for observation only
//
// Handshake semantics: the CPU holds its request and address until it sees
// the single-cycle mem_resp; pmem strobes are held high from state entry
// through the cycle in which pmem_resp pulses and drop the cycle after.
module cache_control
  import lc3b_types::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [ADDR_W-1:0]    mem_address,
  output logic                 mem_resp,
  input  logic                 hit,
  input  logic                 tag1_hit,
  input  logic                 tag2_hit,
  input  logic                 lru_out,
  input  logic                 dirty_1,
  input  logic                 dirty_2,
  input  logic [TAG_W-1:0]     tag_1,
  input  logic [TAG_W-1:0]     tag_2,
  input  logic [INDEX_W-1:0]   index,
  input  logic [LINE_W-1:0]    data_1,
  input  logic [LINE_W-1:0]    data_2,
  output logic                 write_set1,
  output logic                 write_set2,
  output logic                 write_lru,
  output logic                 lru_val,
  output logic                 dirty_in,
  output logic                 memcachedatamux_sel,
  output logic                 datamux_1_sel,
  output logic                 datamux_2_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [ADDR_W-1:0]    pmem_address,
  output logic [LINE_W-1:0]    pmem_wdata,
  input  logic                 pmem_resp,
  output cache_state_t         o_dbg_state
);

  cache_state_t r_state;
  cache_state_t w_next_state;
  logic         r_victim;      // 0 = way 1, 1 = way 2
  logic         w_victim_load;
  logic         w_request;
  logic         w_victim_dirty;

  assign w_request      = mem_read | mem_write;
  assign w_victim_dirty = lru_out ? dirty_2 : dirty_1;
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_victim_load) begin
        r_victim <= lru_out;
      end
    end
  end

  always_comb begin
    w_next_state        = r_state;
    w_victim_load       = 1'b0;
    mem_resp            = 1'b0;
    write_set1          = 1'b0;
    write_set2          = 1'b0;
    write_lru           = 1'b0;
    lru_val             = 1'b0;
    dirty_in            = 1'b0;
    memcachedatamux_sel = 1'b0;
    datamux_1_sel       = 1'b0;
    datamux_2_sel       = 1'b0;
    pmem_read           = 1'b0;
    pmem_write          = 1'b0;
    pmem_address        = '0;
    pmem_wdata          = '0;

    if (reset) begin
      // Everything stays quiet while reset is held, including pmem strobes.
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_request) begin
            if (hit) begin
              mem_resp  = 1'b1;
              write_lru = 1'b1;
              // LRU points at the way that was not just used.
              lru_val   = tag1_hit;
              // A simultaneous read+write is handled as a write.
              if (mem_write) begin
                dirty_in = 1'b1;
                if (tag1_hit) begin
                  write_set1    = 1'b1;
                  datamux_1_sel = 1'b1;
                end else begin
                  write_set2    = 1'b1;
                  datamux_2_sel = 1'b1;
                end
              end
            end else begin
              w_victim_load = 1'b1;
              w_next_state  = w_victim_dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end

        WRITEBACK: begin
          pmem_write = 1'b1;
          if (r_victim) begin
            pmem_address = {tag_2, index, 4'b0000};
            pmem_wdata   = data_2;
          end else begin
            pmem_address = {tag_1, index, 4'b0000};
            pmem_wdata   = data_1;
          end
          if (pmem_resp) begin
            w_next_state = ALLOCATE;
          end
        end

        ALLOCATE: begin
          pmem_read           = 1'b1;
          pmem_address        = {mem_address[ADDR_W-1:OFFSET_W], 4'b0000};
          memcachedatamux_sel = 1'b1;
          if (pmem_resp) begin
            // Fill lands clean; datamux selects stay 0 so the raw pmem line
            // is written rather than a merge with CPU write data.
            if (r_victim) begin
              write_set2 = 1'b1;
            end else begin
              write_set1 = 1'b1;
            end
            w_next_state = IDLE;
          end
        end

        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;
  import lc3b_types::*;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic         mem_resp;
  logic         hit, tag1_hit, tag2_hit, lru_out, dirty_1, dirty_2;
  logic [8:0]   tag_1, tag_2;
  logic [2:0]   index;
  logic [127:0] data_1, data_2;
  logic         write_set1, write_set2, write_lru, lru_val, dirty_in;
  logic         memcachedatamux_sel, datamux_1_sel, datamux_2_sel;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  cache_state_t dbg_state;

  int checks = 0;
  int failures = 0;

  cache_control dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_resp(mem_resp),
    .hit(hit), .tag1_hit(tag1_hit), .tag2_hit(tag2_hit),
    .lru_out(lru_out), .dirty_1(dirty_1), .dirty_2(dirty_2),
    .tag_1(tag_1), .tag_2(tag_2), .index(index),
    .data_1(data_1), .data_2(data_2),
    .write_set1(write_set1), .write_set2(write_set2), .write_lru(write_lru),
    .lru_val(lru_val), .dirty_in(dirty_in),
    .memcachedatamux_sel(memcachedatamux_sel),
    .datamux_1_sel(datamux_1_sel), .datamux_2_sel(datamux_2_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .o_dbg_state(dbg_state)
  );

  // Control bundle, grouped as r_ss_ll_d_m_dd_pp:
  // {mem_resp, write_set1, write_set2, write_lru, lru_val, dirty_in,
  //  memcachedatamux_sel, datamux_1_sel, datamux_2_sel, pmem_read, pmem_write}
  logic [10:0] ctl;
  assign ctl = {mem_resp, write_set1, write_set2, write_lru, lru_val, dirty_in,
                memcachedatamux_sel, datamux_1_sel, datamux_2_sel,
                pmem_read, pmem_write};

  localparam logic [10:0] C_ZERO      = 11'b0_00_00_0_0_00_00;
  localparam logic [10:0] C_RD_HIT_1  = 11'b1_00_11_0_0_00_00;
  localparam logic [10:0] C_RD_HIT_2  = 11'b1_00_10_0_0_00_00;
  localparam logic [10:0] C_WR_HIT_1  = 11'b1_10_11_1_0_10_00;
  localparam logic [10:0] C_WR_HIT_2  = 11'b1_01_10_1_0_01_00;
  localparam logic [10:0] C_ALLOC     = 11'b0_00_00_0_1_00_10;
  localparam logic [10:0] C_FILL_1    = 11'b0_10_00_0_1_00_10;
  localparam logic [10:0] C_FILL_2    = 11'b0_01_00_0_1_00_10;
  localparam logic [10:0] C_WB        = 11'b0_00_00_0_0_00_01;

  // Scoreboard: expected pmem addresses in the order they should appear
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk(tag, {112'd0, pmem_address}, {112'd0, e});
  endtask

  // Driver: move to the inactive edge, settle, then sample comb outputs.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; hit = 0; tag1_hit = 0; tag2_hit = 0;
    pmem_resp = 0;
  endtask

  initial begin
    reset = 1; mem_read = 1; mem_write = 0; mem_address = 16'h0000;
    hit = 0; tag1_hit = 0; tag2_hit = 0; lru_out = 0;
    dirty_1 = 0; dirty_2 = 0; tag_1 = '0; tag_2 = '0; index = '0;
    data_1 = '0; data_2 = '0; pmem_resp = 0;

    // Reset held 2 cycles with a pending read: everything quiet.
    step(); settle(); chk("reset_c1_ctl", {117'd0, ctl}, {117'd0, C_ZERO});
    step(); settle(); chk("reset_c2_ctl", {117'd0, ctl}, {117'd0, C_ZERO});
    chk("reset_addr", {112'd0, pmem_address}, 128'd0);
    @(posedge clk);
    step(); reset = 0; idle_inputs(); settle();
    chk("post_reset_state", {126'd0, dbg_state}, {126'd0, IDLE});
    chk("idle_noreq_ctl", {117'd0, ctl}, {117'd0, C_ZERO});

    // Read hit in way 1.
    step(); mem_read = 1; hit = 1; tag1_hit = 1; settle();
    chk("rd_hit1_ctl", {117'd0, ctl}, {117'd0, C_RD_HIT_1});
    // Write hit in way 2.
    step(); mem_read = 0; mem_write = 1; tag1_hit = 0; tag2_hit = 1; settle();
    chk("wr_hit2_ctl", {117'd0, ctl}, {117'd0, C_WR_HIT_2});
    // Both tags match: way 1 wins.
    step(); tag1_hit = 1; tag2_hit = 1; settle();
    chk("wr_both_ctl", {117'd0, ctl}, {117'd0, C_WR_HIT_1});
    // Read and write together with a way-1 hit: treated as a write.
    step(); mem_read = 1; mem_write = 1; tag2_hit = 0; settle();
    chk("rdwr_hit1_ctl", {117'd0, ctl}, {117'd0, C_WR_HIT_1});
    // pmem_resp while idle is ignored.
    step(); idle_inputs(); pmem_resp = 1; settle();
    chk("idle_resp_ctl", {117'd0, ctl}, {117'd0, C_ZERO});
    step(); pmem_resp = 0; settle();
    chk("idle_resp_state", {126'd0, dbg_state}, {126'd0, IDLE});

    // Clean miss: victim way 2 (clean) even though way 1 is dirty.
    step(); mem_read = 1; mem_address = 16'h1234; lru_out = 1;
    dirty_2 = 0; dirty_1 = 1; settle();
    chk("clean_detect_ctl", {117'd0, ctl}, {117'd0, C_ZERO});
    exp_q.push_back(16'h1230); exp_q.push_back(16'h1230);
    exp_q.push_back(16'h1230);
    step(); lru_out = 0; settle();   // victim must stay registered as way 2
    chk("clean_alloc1_ctl", {117'd0, ctl}, {117'd0, C_ALLOC});
    chk_addr("clean_alloc1_addr");
    step(); settle();
    chk("clean_alloc2_ctl", {117'd0, ctl}, {117'd0, C_ALLOC});
    chk_addr("clean_alloc2_addr");
    step(); pmem_resp = 1; settle();
    chk("clean_fill_ctl", {117'd0, ctl}, {117'd0, C_FILL_2});
    chk_addr("clean_fill_addr");
    // Fifth cycle of the request: line now present in way 2.
    step(); pmem_resp = 0; hit = 1; tag2_hit = 1; settle();
    chk("clean_rehit_ctl", {117'd0, ctl}, {117'd0, C_RD_HIT_2});
    chk("clean_rehit_state", {126'd0, dbg_state}, {126'd0, IDLE});

    // Dirty miss: victim way 1, tag 0x1A5, set 2 -> writeback to 0xD2A0.
    step(); idle_inputs(); mem_read = 1; mem_address = 16'h5678;
    lru_out = 0; dirty_1 = 1; dirty_2 = 0; tag_1 = 9'h1A5; tag_2 = 9'h0F0;
    index = 3'd2;
    data_1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    data_2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    settle();
    chk("dirty_detect_ctl", {117'd0, ctl}, {117'd0, C_ZERO});
    exp_q.push_back(16'hD2A0); exp_q.push_back(16'hD2A0);
    exp_q.push_back(16'h5670); exp_q.push_back(16'h5670);
    step(); settle();
    chk("dirty_wb1_ctl", {117'd0, ctl}, {117'd0, C_WB});
    chk_addr("dirty_wb1_addr");
    chk("dirty_wb1_data", pmem_wdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    step(); pmem_resp = 1; settle();
    chk("dirty_wb2_ctl", {117'd0, ctl}, {117'd0, C_WB});
    chk_addr("dirty_wb2_addr");
    step(); pmem_resp = 0; lru_out = 1; settle();
    chk("dirty_alloc_ctl", {117'd0, ctl}, {117'd0, C_ALLOC});
    chk_addr("dirty_alloc_addr");
    chk("dirty_alloc_wdata", pmem_wdata, 128'd0);
    step(); pmem_resp = 1; settle();
    chk("dirty_fill_ctl", {117'd0, ctl}, {117'd0, C_FILL_1});
    chk_addr("dirty_fill_addr");
    step(); pmem_resp = 0; hit = 1; tag1_hit = 1; settle();
    chk("dirty_rehit_ctl", {117'd0, ctl}, {117'd0, C_RD_HIT_1});

    // Reset mid-ALLOCATE: strobes drop in the reset cycle, no fill.
    step(); idle_inputs(); mem_read = 1; mem_address = 16'h0AB0;
    lru_out = 1; dirty_2 = 0; settle();
    step(); settle();
    chk("rst_alloc_state", {126'd0, dbg_state}, {126'd0, ALLOCATE});
    step(); reset = 1; pmem_resp = 1; settle();
    chk("rst_mid_ctl", {117'd0, ctl}, {117'd0, C_ZERO});
    step(); reset = 0; idle_inputs(); settle();
    chk("rst_after_state", {126'd0, dbg_state}, {126'd0, IDLE});
    chk("rst_after_ctl", {117'd0, ctl}, {117'd0, C_ZERO});

    // Request dropped mid-miss: fill completes, then no mem_resp.
    step(); mem_write = 1; mem_address = 16'h4440; lru_out = 0; dirty_1 = 0;
    settle();
    step(); mem_write = 0; settle();
    chk("drop_alloc_ctl", {117'd0, ctl}, {117'd0, C_ALLOC});
    step(); pmem_resp = 1; settle();
    chk("drop_fill_ctl", {117'd0, ctl}, {117'd0, C_FILL_1});
    step(); pmem_resp = 0; settle();
    chk("drop_idle_ctl", {117'd0, ctl}, {117'd0, C_ZERO});
    chk("drop_idle_state", {126'd0, dbg_state}, {126'd0, IDLE});

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
